// File: rtl/y_trace_pkg.sv
// y_trace_pkg: constants and types shared by the Y trace capture block.
//   VEC_W          width of the sampled stimulus vector A..F
//   DEFAULT_DEPTH  default FIFO entry count
//   DEFAULT_TS_W   default timestamp width
//   trace_entry_t  one logged record {ts, vec, y}, y in the LSB
package y_trace_pkg;

  localparam int VEC_W         = 6;
  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_TS_W  = 16;

  typedef struct packed {
    logic [DEFAULT_TS_W-1:0] ts;
    logic [VEC_W-1:0]        vec;
    logic                    y;
  } trace_entry_t;

  // Width of a packed entry for an arbitrary timestamp width.
  function automatic int entry_width(input int ts_w);
    return ts_w + VEC_W + 1;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO holding trace entries.
//   clk, rst_n        clock and asynchronous active-low reset
//   wr_en, wr_data    push request and data
//   rd_en             pop request; ignored while empty
//   rd_data, rd_valid oldest entry, valid one cycle after an accepted pop
//   empty, full       status, combinational from count
//   count             current occupancy (0..DEPTH)
// A push while full is accepted only when a pop happens in the same cycle.
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [W-1:0]           wr_data,
  input  logic                   rd_en,
  output logic [W-1:0]           rd_data,
  output logic                   rd_valid,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic [W-1:0]     rd_data_reg;
  logic             rd_valid_reg;
  logic             do_rd;
  logic             do_wr;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == (PTR_W+1)'(DEPTH));

  assign do_rd = rd_en && !empty;
  // When full, the slot under wr_ptr is the one being popped this cycle.
  assign do_wr = wr_en && (!full || do_rd);

  // Storage carries no reset so it can map onto block RAM; the pointer
  // reset alone discards the contents.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= do_rd;
      if (do_rd) begin
        rd_data_reg <= mem[rd_ptr_reg];
        rd_ptr_reg  <= rd_ptr_reg + PTR_W'(1);
      end
      if (do_wr) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;
  assign count    = count_reg;

endmodule

// File: rtl/y_trace_capture.sv
// y_trace_capture: logs changes of {vec_in, y_in} with a timestamp.
//   clk, rst_n   clock and asynchronous active-low reset
//   vec_in       sampled stimulus A..F (bit 5 = A, bit 0 = F)
//   y_in         sampled output Y of the upstream block
//   capture_en   enables event detection and logging
//   rd_en        pops one entry
//   clr_ovf      clears the sticky overflow flag
//   rd_data      popped entry {ts, vec, y}
//   rd_valid     one-cycle pulse marking rd_data
//   empty, full, count  FIFO status
//   overflow     sticky, set when an event is dropped
// An event is the first enabled cycle (arm sample) or any enabled cycle
// whose sample differs from the previous enabled sample.
module y_trace_capture
  import y_trace_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int TS_W  = DEFAULT_TS_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [VEC_W-1:0]       vec_in,
  input  logic                   y_in,
  input  logic                   capture_en,
  input  logic                   rd_en,
  input  logic                   clr_ovf,
  output logic [TS_W+VEC_W:0]    rd_data,
  output logic                   rd_valid,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int ENTRY_W = entry_width(TS_W);

  logic [TS_W-1:0]  ts_reg;
  logic [VEC_W:0]   prev_sample_reg;
  logic             cap_en_d_reg;
  logic             overflow_reg;
  logic [VEC_W:0]   sample;
  logic             trace_event;
  logic             drop;
  logic [ENTRY_W-1:0] wr_data;

  assign sample      = {vec_in, y_in};
  assign trace_event = capture_en && (!cap_en_d_reg || (sample != prev_sample_reg));
  // A full FIFO still accepts the event when a pop frees a slot this cycle.
  assign drop        = trace_event && full && !rd_en;
  assign wr_data     = {ts_reg, sample};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_reg          <= '0;
      prev_sample_reg <= '0;
      cap_en_d_reg    <= 1'b0;
      overflow_reg    <= 1'b0;
    end else begin
      ts_reg       <= ts_reg + TS_W'(1);
      cap_en_d_reg <= capture_en;
      if (capture_en) begin
        prev_sample_reg <= sample;
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (clr_ovf) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  assign overflow = overflow_reg;

  trace_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (trace_event),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .empty    (empty),
    .full     (full),
    .count    (count)
  );

endmodule

// File: tb/tb_y_trace_capture.sv
// tb_y_trace_capture: scenario-driven bench for y_trace_capture.
// Inputs change on the falling edge; outputs are sampled on the falling
// edge after the rising edge that updated them.
module tb_y_trace_capture;
  import y_trace_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [5:0]  vec_in;
  logic        y_in;
  logic        capture_en;
  logic        rd_en;
  logic        clr_ovf;
  logic [22:0] rd_data;
  logic        rd_valid;
  logic        empty;
  logic        full;
  logic [3:0]  count;
  logic        overflow;

  int total = 0;
  int bad   = 0;
  trace_entry_t sb[$];
  trace_entry_t exp_e;
  trace_entry_t last_read;
  logic [15:0]  cyc;
  logic         v;
  logic [22:0]  d;

  y_trace_capture #(.DEPTH(8), .TS_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vec_in     (vec_in),
    .y_in       (y_in),
    .capture_en (capture_en),
    .rd_en      (rd_en),
    .clr_ovf    (clr_ovf),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference timestamp: the value the DUT logs for an event at the next rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 16'd0;
    else        cyc <= cyc + 16'd1;
  end

  function automatic trace_entry_t mk(input logic [15:0] ts, input logic [5:0] vec, input logic y);
    trace_entry_t e;
    e.ts  = ts;
    e.vec = vec;
    e.y   = y;
    return e;
  endfunction

  task automatic do_read(output logic rv, output logic [22:0] rdat);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    rv   = rd_valid;
    rdat = rd_data;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; vec_in = '0; y_in = 1'b0; capture_en = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (empty !== 1'b1)  begin bad++; $display("FAIL reset_empty got=%b want=1", empty); end
    total++; if (full !== 1'b0)   begin bad++; $display("FAIL reset_full got=%b want=0", full); end
    total++; if (count !== 4'd0)  begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b want=0", rd_valid); end
    total++; if (rd_data !== 23'd0) begin bad++; $display("FAIL reset_rd_data got=%h want=0", rd_data); end
    $display("reset: empty=%b full=%b count=%0d", empty, full, count);
  endtask

  task automatic test_single;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    capture_en = 1'b1; vec_in = 6'b100100; y_in = 1'b0;
    sb.push_back(mk(16'd3, 6'b100100, 1'b0));
    repeat (5) @(negedge clk);
    capture_en = 1'b0;
    @(negedge clk);
    total++; if (count !== 4'd1) begin bad++; $display("FAIL single_count got=%0d want=1", count); end
    do_read(v, d);
    exp_e = sb.pop_front();
    last_read = exp_e;
    total++; if (v !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", v); end
    total++; if (d !== exp_e) begin bad++; $display("FAIL single_data got=%h want=%h", d, exp_e); end
    $display("single: rd_data=%h", d);
    @(negedge clk);
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL single_pulse got=%b want=0", rd_valid); end
  endtask

  task automatic test_sequence;
    logic [5:0] seq [4];
    seq[0] = 6'b100100; seq[1] = 6'b001100; seq[2] = 6'b101100; seq[3] = 6'b101101;
    for (int i = 0; i < 4; i++) begin
      capture_en = 1'b1; vec_in = seq[i]; y_in = 1'b0;
      sb.push_back(mk(cyc, seq[i], 1'b0));
      @(negedge clk);
    end
    capture_en = 1'b0;
    total++; if (count !== 4'd4) begin bad++; $display("FAIL seq_count got=%0d want=4", count); end
    for (int i = 0; i < 4; i++) begin
      do_read(v, d);
      exp_e = sb.pop_front();
      last_read = exp_e;
      total++; if (v !== 1'b1 || d !== exp_e) begin bad++; $display("FAIL seq_read%0d got=%b/%h want=1/%h", i, v, d, exp_e); end
      $display("seq read %0d: rd_data=%h", i, d);
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 9; i++) begin
      capture_en = 1'b1; vec_in = 6'(i + 10); y_in = i[0];
      if (i < 8) sb.push_back(mk(cyc, 6'(i + 10), i[0]));
      @(negedge clk);
    end
    capture_en = 1'b0;
    total++; if (full !== 1'b1)     begin bad++; $display("FAIL ovf_full got=%b want=1", full); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", overflow); end
    total++; if (count !== 4'd8)    begin bad++; $display("FAIL ovf_count got=%0d want=8", count); end
    $display("overflow: full=%b overflow=%b count=%0d", full, overflow, count);
  endtask

  task automatic test_full_rw;
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clr_ovf got=%b want=0", overflow); end
    capture_en = 1'b1; vec_in = 6'b111000; y_in = 1'b1; rd_en = 1'b1;
    exp_e = sb.pop_front();
    sb.push_back(mk(cyc, 6'b111000, 1'b1));
    @(negedge clk);
    capture_en = 1'b0; rd_en = 1'b0;
    total++; if (rd_valid !== 1'b1 || rd_data !== exp_e) begin bad++; $display("FAIL fullrw_read got=%b/%h want=1/%h", rd_valid, rd_data, exp_e); end
    total++; if (count !== 4'd8)    begin bad++; $display("FAIL fullrw_count got=%0d want=8", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fullrw_ovf got=%b want=0", overflow); end
    for (int i = 0; i < 8; i++) begin
      do_read(v, d);
      exp_e = sb.pop_front();
      last_read = exp_e;
      total++; if (v !== 1'b1 || d !== exp_e) begin bad++; $display("FAIL drain_read%0d got=%b/%h want=1/%h", i, v, d, exp_e); end
      $display("drain read %0d: rd_data=%h", i, d);
    end
  endtask

  task automatic test_empty_read;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL empty_flag got=%b want=1", empty); end
    do_read(v, d);
    total++; if (v !== 1'b0)        begin bad++; $display("FAIL empty_rd_valid got=%b want=0", v); end
    total++; if (d !== last_read)   begin bad++; $display("FAIL empty_rd_hold got=%h want=%h", d, last_read); end
    // Write and read together while empty: only the write happens.
    capture_en = 1'b1; vec_in = 6'b000011; y_in = 1'b0; rd_en = 1'b1;
    sb.push_back(mk(cyc, 6'b000011, 1'b0));
    @(negedge clk);
    rd_en = 1'b0;
    total++; if (rd_valid !== 1'b0 || count !== 4'd1) begin bad++; $display("FAIL empty_wr_rd got=%b/%0d want=0/1", rd_valid, count); end
    for (int i = 1; i < 8; i++) begin
      vec_in = 6'(i + 20); y_in = 1'b0;
      sb.push_back(mk(cyc, 6'(i + 20), 1'b0));
      @(negedge clk);
    end
    // Drop together with a clear: the drop wins.
    vec_in = 6'b111111; y_in = 1'b1; clr_ovf = 1'b1;
    @(negedge clk);
    capture_en = 1'b0; clr_ovf = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL drop_clr_ovf got=%b want=1", overflow); end
    total++; if (count !== 4'd8)    begin bad++; $display("FAIL drop_count got=%0d want=8", count); end
    $display("drop+clr: overflow=%b count=%0d", overflow, count);
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 3; i++) begin
      do_read(v, d);
      exp_e = sb.pop_front();
      total++; if (v !== 1'b1 || d !== exp_e) begin bad++; $display("FAIL pre_rst_read%0d got=%b/%h want=1/%h", i, v, d, exp_e); end
    end
    total++; if (count !== 4'd5) begin bad++; $display("FAIL pre_rst_count got=%0d want=5", count); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (empty !== 1'b1 || count !== 4'd0) begin bad++; $display("FAIL async_rst got=%b/%0d want=1/0", empty, count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL async_rst_ovf got=%b want=0", overflow); end
    $display("async reset: empty=%b count=%0d", empty, count);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    // Sample equals the cleared previous-sample register; only arming logs it.
    capture_en = 1'b1; vec_in = 6'b000000; y_in = 1'b0;
    sb.push_back(mk(16'd2, 6'b000000, 1'b0));
    repeat (4) @(negedge clk);
    capture_en = 1'b0;
    @(negedge clk);
    total++; if (count !== 4'd1) begin bad++; $display("FAIL post_rst_count got=%0d want=1", count); end
    do_read(v, d);
    exp_e = sb.pop_front();
    total++; if (v !== 1'b1 || d !== exp_e) begin bad++; $display("FAIL post_rst_read got=%b/%h want=1/%h", v, d, exp_e); end
    $display("post reset read: rd_data=%h", d);
  endtask

  initial begin
    test_reset();
    test_single();
    test_sequence();
    test_overflow();
    test_full_rw();
    test_empty_read();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/y_trace_capture.md
Y_TRACE_CAPTURE -- requirements
Module: y_trace_capture

Interface
- REQ-001: Parameter DEPTH, default 8, FIFO entry count; power of two, at least 2.
- REQ-002: Parameter TS_W, default 16, timestamp width in bits.
- REQ-003: clk  input  1  single clock; all state updates on the rising edge.
- REQ-004: rst_n  input  1  asynchronous, active-low reset.
- REQ-005: vec_in  input  6  sampled stimulus vector A..F; bit 5 = A, bit 0 = F.
- REQ-006: y_in  input  1  sampled output Y of the upstream combinational block.
- REQ-007: capture_en  input  1  high enables event detection and logging.
- REQ-008: rd_en  input  1  read request, pops one entry.
- REQ-009: clr_ovf  input  1  synchronous clear of the overflow flag.
- REQ-010: rd_data  output  TS_W+7  popped entry {timestamp, vec, y}, with y as the LSB.
- REQ-011: rd_valid  output  1  one-cycle pulse marking rd_data valid.
- REQ-012: empty, full  output  1 each  FIFO status.
- REQ-013: count  output  log2(DEPTH)+1  current occupancy.
- REQ-014: overflow  output  1  sticky flag; set when an event is dropped.

Function
- REQ-015: ts is a free-running TS_W-bit cycle counter that wraps from all-ones to 0 and runs regardless of capture_en.
- REQ-016: An event occurs in any cycle where capture_en=1 and either of these holds:
  - capture_en was 0 in the previous cycle (arm sample), or
  - {vec_in,y_in} differs from the registered previous sample.
- REQ-017: The previous-sample register loads {vec_in,y_in} every cycle that capture_en=1.
- REQ-018: Each event writes {ts, vec_in, y_in} into the FIFO in the same cycle; the logged ts is the pre-increment ts value of that cycle.
- REQ-019: An event while full and rd_en=0 is dropped, sets overflow, and leaves FIFO contents unchanged.
- REQ-020: An event while full and rd_en=1 is accepted; count stays DEPTH.
- REQ-021: rd_en while empty is ignored:
  - no rd_valid;
  - rd_data holds its value;
  - pointers unchanged.
- REQ-022: rd_en while not empty updates rd_data with the oldest entry one cycle later and pulses rd_valid high for exactly that cycle (read latency 1).
- REQ-023: Simultaneous write and read with 0 < count < DEPTH leaves count unchanged.
- REQ-024: Simultaneous write and read with count=0 writes only; the read is ignored per REQ-021.
- REQ-025: Read and write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
- REQ-026: empty = (count==0) and full = (count==DEPTH), both combinational from count.
- REQ-027: overflow priority:
  - clr_ovf=1 clears overflow;
  - a drop in the same cycle as clr_ovf=1 leaves overflow set (set wins).

Reset
- REQ-028: rst_n low immediately resets every output and state element, independent of clk:
  - ts=0, pointers=0, count=0;
  - empty=1, full=0, overflow=0, rd_valid=0;
  - rd_data=0;
  - previous sample=0, capture_en history=0.
- REQ-029: Reset asserted mid-operation discards all FIFO contents.
- REQ-030: The first capture_en=1 cycle after reset deassertion is an arm event per REQ-016.

Structure
- REQ-031: A shared package y_trace_pkg holds:
  - VEC_W=6;
  - the entry record type (ts, vec, y);
  - the default DEPTH and TS_W constants.
- REQ-032: One sub-module, trace_fifo, implements storage, pointers, count and flags.
- REQ-033: Event detection, the timestamp counter and the overflow flag live in the top level.

Verification
- REQ-034: Reset release, then capture_en=1 at ts=3 with vec=6'b100100, y=0 and held stable 5 cycles:
  - exactly one entry is logged;
  - the next read returns {3, 6'b100100, 0} with rd_valid one cycle after rd_en.
- REQ-035: Apply vec sequence 100100, 001100, 101100, 101101 on consecutive cycles:
  - four entries are logged with consecutive ts values, read back in order.
- REQ-036: Generate 9 events with DEPTH=8 and no reads:
  - full=1, overflow=1, count=8;
  - the first 8 events are read back intact.
- REQ-037: With full=1, an event and rd_en in the same cycle:
  - count stays 8, overflow stays 0;
  - the new entry is read last.
- REQ-038: rd_en while empty yields no rd_valid; a drop and clr_ovf in the same cycle leave overflow=1.
- REQ-039: Assert rst_n=0 asynchronously between clock edges with count=5:
  - empty=1 and count=0 immediately, before the next edge;
  - ts restarts from 0 after release.
